mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the CPU fetch port (I) and load/store port (D).

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between fetch (I) and load/store (D) ports.
// Define MEMARB_RR_EN for round-robin ties instead of D priority with starvation guard.
module mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            I_REQ,
  input  logic [AW-1:0]   I_ADDR,
  output logic            I_GNT,
  output logic            I_RVALID,
  output logic [DW-1:0]   I_RDATA,
  input  logic            D_REQ,
  input  logic            D_WE,
  input  logic [AW-1:0]   D_ADDR,
  input  logic [DW-1:0]   D_WDATA,
  input  logic [DW/8-1:0] D_BE,
  output logic            D_GNT,
  output logic            D_RVALID,
  output logic [DW-1:0]   D_RDATA,
  output logic            M_EN,
  output logic            M_WE,
  output logic [AW-1:0]   M_ADDR,
  output logic [DW-1:0]   M_WDATA,
  output logic [DW/8-1:0] M_BE,
  input  logic [DW-1:0]   M_RDATA,
  output logic            BUSY
);

  localparam int BW = DW / 8;
  localparam logic [1:0] WINIT =
    (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic            win_d_q, win_d_d;
  logic            m_en_q, m_en_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [BW-1:0]   m_be_q, m_be_d;
  logic            i_gnt_q, i_gnt_d;
  logic            d_gnt_q, d_gnt_d;
  logic            arb, any_req, pick_d;

`ifdef MEMARB_RR_EN
  logic            last_d_q, last_d_d;
`else
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0]      starve_q, starve_d;
`endif

  assign arb     = (state_q == S_IDLE) || (state_q == S_RESP);
  assign any_req = I_REQ | D_REQ;

`ifdef MEMARB_RR_EN
  assign pick_d = D_REQ & (~I_REQ | ~last_d_q);
`else
  assign pick_d = D_REQ & (~I_REQ | (starve_q != SMAX));
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      win_d_q   <= 1'b0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      i_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
`ifdef MEMARB_RR_EN
      last_d_q  <= 1'b0;
`else
      starve_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      win_d_q   <= win_d_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
      i_gnt_q   <= i_gnt_d;
      d_gnt_q   <= d_gnt_d;
`ifdef MEMARB_RR_EN
      last_d_q  <= last_d_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (MEM_LAT > 1) begin
          state_d = S_WAIT;
          wcnt_d  = WINIT;
        end else begin
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 2'd0) state_d = S_RESP;
        else wcnt_d = wcnt_q - 2'd1;
      end
      S_RESP: begin
        state_d = any_req ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Winner's request is captured here so every M_* and GNT leaves a flop.
  always_comb begin
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    m_addr_d  = '0;
    m_wdata_d = '0;
    m_be_d    = '0;
    i_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    win_d_d   = win_d_q;
`ifdef MEMARB_RR_EN
    last_d_d  = last_d_q;
`else
    starve_d  = starve_q;
    if (!I_REQ) starve_d = '0;
`endif
    if (arb && any_req) begin
      m_en_d  = 1'b1;
      win_d_d = pick_d;
`ifdef MEMARB_RR_EN
      last_d_d = pick_d;
`else
      if (I_REQ) starve_d = pick_d ? starve_q + 4'd1 : 4'd0;
`endif
      if (pick_d) begin
        m_we_d    = D_WE;
        m_addr_d  = D_ADDR;
        m_wdata_d = D_WDATA;
        m_be_d    = D_BE;
        d_gnt_d   = 1'b1;
      end else begin
        m_addr_d  = I_ADDR;
        m_be_d    = '1;
        i_gnt_d   = 1'b1;
      end
    end
  end

  always_comb begin
    BUSY     = (state_q != S_IDLE);
    I_RVALID = (state_q == S_RESP) & ~win_d_q;
    D_RVALID = (state_q == S_RESP) &  win_d_q;
    I_RDATA  = I_RVALID ? M_RDATA : '0;
    D_RDATA  = D_RVALID ? M_RDATA : '0;
    I_GNT    = i_gnt_q;
    D_GNT    = d_gnt_q;
    M_EN     = m_en_q;
    M_WE     = m_we_q;
    M_ADDR   = m_addr_q;
    M_WDATA  = m_wdata_q;
    M_BE     = m_be_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 2-cycle-latency memory model.
// Grant-order expectations follow MEMARB_RR_EN when defined.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          CLK, RST;
  logic          I_REQ, I_GNT, I_RVALID;
  logic [AW-1:0] I_ADDR;
  logic [DW-1:0] I_RDATA;
  logic          D_REQ, D_WE, D_GNT, D_RVALID;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA, D_RDATA;
  logic [3:0]    D_BE;
  logic          M_EN, M_WE, BUSY;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_WDATA, M_RDATA;
  logic [3:0]    M_BE;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(3)
  ) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT),
    .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR),
    .D_WDATA(D_WDATA), .D_BE(D_BE), .D_GNT(D_GNT),
    .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_EN(M_EN), .M_WE(M_WE), .M_ADDR(M_ADDR),
    .M_WDATA(M_WDATA), .M_BE(M_BE), .M_RDATA(M_RDATA),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: data appears two cycles after the M_EN cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_p1, rd_p2;
  assign M_RDATA = rd_p2;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[1] = 32'h1111_2222;
    mem[4] = 32'hFD00_0293;
    mem[8] = 32'h0BAD_F00D;
    rd_p1  = '0;
    rd_p2  = '0;
  end

  always @(posedge CLK) begin
    if (M_EN) begin
      rd_p1 <= mem[M_ADDR];
      if (M_WE)
        for (int b = 0; b < 4; b++)
          if (M_BE[b]) mem[M_ADDR][8*b +: 8] <= M_WDATA[8*b +: 8];
    end
    rd_p2 <= rd_p1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " outs"},
        {26'd0, I_GNT, I_RVALID, D_GNT, D_RVALID, M_EN, BUSY}, 32'd0);
    chk({tag, " m_bus"},
        {M_WE, M_BE, 17'd0, M_ADDR}, 32'd0);
    chk({tag, " wdata"}, M_WDATA, 32'd0);
    chk({tag, " rdata"}, I_RDATA | D_RDATA, 32'd0);
  endtask

  task automatic do_fetch(input string tag,
                          input logic [AW-1:0] a,
                          input logic [31:0] exp);
    I_REQ  = 1'b1;
    I_ADDR = a;
    step;
    chk({tag, " c1 gnt"}, {30'd0, I_GNT, D_GNT}, 32'h2);
    chk({tag, " c1 men/we"}, {30'd0, M_EN, M_WE}, 32'h2);
    chk({tag, " c1 addr"}, 32'(M_ADDR), 32'(a));
    chk({tag, " c1 be"}, 32'(M_BE), 32'hF);
    I_REQ = 1'b0;
    step;
    chk({tag, " c2"}, {29'd0, I_GNT, M_EN, I_RVALID}, 32'd0);
    step;
    chk({tag, " c3 rv"}, {30'd0, I_RVALID, D_RVALID}, 32'h2);
    chk({tag, " c3 data"}, I_RDATA, exp);
    step;
    chk({tag, " c4 idle"}, {30'd0, I_RVALID, BUSY}, 32'd0);
  endtask

  logic [1:0] gnts [8];
  logic [1:0] gexp [8];
  int         ng;
  logic       saw_en;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    I_REQ = 0; I_ADDR = '0;
    D_REQ = 0; D_WE = 0; D_ADDR = '0; D_WDATA = '0; D_BE = '0;
    #2;
    chk_idle_outputs("reset");
    step; step;
    chk_idle_outputs("reset held");
    RST = 1'b0;
    saw_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step;
      saw_en |= M_EN;
    end
    chk("no req m_en", 32'(saw_en), 32'd0);

    do_fetch("fetch", 10'h004, 32'hFD00_0293);

    // tie: D first, I after D's response
    I_REQ = 1; I_ADDR = 10'h001;
    D_REQ = 1; D_WE = 0; D_ADDR = 10'h008;
    step;
    chk("tie c1 gnt", {30'd0, I_GNT, D_GNT}, 32'h1);
    chk("tie c1 addr", 32'(M_ADDR), 32'h8);
    D_REQ = 0;
    step; step;
    chk("tie c3 rv", {30'd0, I_RVALID, D_RVALID}, 32'h1);
    chk("tie c3 ddata", D_RDATA, 32'h0BAD_F00D);
    chk("tie c3 idata", I_RDATA, 32'd0);
    step;
    chk("tie c4 gnt", {30'd0, I_GNT, D_GNT}, 32'h2);
    chk("tie c4 addr", 32'(M_ADDR), 32'h1);
    I_REQ = 0;
    step; step;
    chk("tie c6 rv", {30'd0, I_RVALID, D_RVALID}, 32'h2);
    chk("tie c6 idata", I_RDATA, 32'h1111_2222);
    step;

    // starvation / fairness
    I_REQ = 1; I_ADDR = 10'h020;
    D_REQ = 1; D_WE = 0; D_ADDR = 10'h030;
    for (int i = 0; i < 8; i++) gnts[i] = 2'd3;
`ifdef MEMARB_RR_EN
    for (int i = 0; i < 8; i++) gexp[i] = (i % 2 == 0) ? 2'd1 : 2'd2;
`else
    for (int i = 0; i < 8; i++) gexp[i] = (i % 4 == 3) ? 2'd2 : 2'd1;
`endif
    ng = 0;
    for (int c = 0; c < 60 && ng < 8; c++) begin
      step;
      if (I_GNT || D_GNT) begin
        gnts[ng] = {I_GNT, D_GNT};
        ng++;
      end
    end
    I_REQ = 0; D_REQ = 0;
    for (int i = 0; i < 8; i++)
      chk($sformatf("grant %0d", i), 32'(gnts[i]), 32'(gexp[i]));
    for (int c = 0; c < 10 && BUSY; c++) step;
    chk("starve drain", 32'(BUSY), 32'd0);

    // store then read back
    D_REQ = 1; D_WE = 1; D_ADDR = 10'h010;
    D_WDATA = 32'hDEAD_BEEF; D_BE = 4'b0011;
    step;
    chk("st c1 gnt", {30'd0, I_GNT, D_GNT}, 32'h1);
    chk("st c1 we/be", {27'd0, M_WE, M_BE}, 32'h13);
    chk("st c1 wdata", M_WDATA, 32'hDEAD_BEEF);
    chk("st c1 addr", 32'(M_ADDR), 32'h10);
    D_REQ = 0; D_WE = 0; D_BE = '0;
    step; step;
    chk("st c3 rv", {30'd0, I_RVALID, D_RVALID}, 32'h1);
    step;
    D_REQ = 1; D_ADDR = 10'h010;
    step;
    chk("ld c1 we", {30'd0, D_GNT, M_WE}, 32'h2);
    D_REQ = 0;
    step; step;
    chk("ld c3 rv", 32'(D_RVALID), 32'd1);
    chk("ld c3 data", D_RDATA, 32'h0000_BEEF);
    step;

    // reset asserted while waiting on memory
    I_REQ = 1; I_ADDR = 10'h004;
    step;
    chk("rst c1 gnt", 32'(I_GNT), 32'd1);
    I_REQ = 0;
    step;
    chk("rst c2 busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    #1;
    chk_idle_outputs("rst mid");
    #2;
    RST = 1'b0;
    step;
    chk("rst c3 no rv", {30'd0, I_RVALID, BUSY}, 32'd0);
    step;
    do_fetch("refetch", 10'h004, 32'hFD00_0293);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
